// File: rtl/spm_boot_loader.sv
// spm_boot_loader
//   Byte-stream program loader in front of pipeline_cpu_top. It receives a
//   framed image over a valid/ready byte interface:
//     0xA5, N[7:0], N[15:8], N*4 little-endian data bytes, CSUM
//   where CSUM is the 8-bit sum of the data bytes. Each assembled word is
//   written to the SPM through the CPU's test_spm_* port at
//   BASE_ADDR + 4*i. After a load with a good checksum, cpu_en is raised and
//   held until reset.
//
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     rx_data/valid     incoming byte stream
//     rx_ready          loader can take a byte this cycle
//     test_spm_addr     SPM byte address (ADDR_W bits, truncating)
//     test_spm_as_      SPM address strobe, active low
//     test_spm_rw       RW_WRITE during a strobe, RW_READ otherwise
//     test_spm_wr_data  word written to SPM
//     cpu_en            core enable after a good load
//     load_done         sticky, good frame loaded
//     load_err          sticky until the next 0xA5 start byte
module spm_boot_loader #(
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned MAX_WORDS   = 64,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned ADDR_W      = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] test_spm_addr,
    output logic              test_spm_as_,
    output logic              test_spm_rw,
    output logic [31:0]       test_spm_wr_data,
    output logic              cpu_en,
    output logic              load_done,
    output logic              load_err
);

    localparam logic        RW_READ  = 1'b1;
    localparam logic        RW_WRITE = 1'b0;
    localparam logic [7:0]  START    = 8'hA5;
    localparam int unsigned IDX_W    = $clog2(MAX_WORDS + 1);
    localparam int unsigned TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [TO_W-1:0]  TO_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t             state;
    logic [15:0]        len;
    logic [23:0]        word;
    logic [1:0]         byte_cnt;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         csum;
    logic [TO_W-1:0]    to_cnt;

    logic               accept;
    logic               timed;
    logic               timeout_hit;
    logic [IDX_W-1:0]   next_idx;
    logic               more_words;
    logic [15:0]        len_new;
    logic [ADDR_W-1:0]  wr_addr;

    assign accept     = rx_valid & rx_ready;
    assign timed      = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CSUM);
    // An accepted byte beats the timeout in the same cycle.
    assign timeout_hit = (TIMEOUT_CYC != 0) && timed && !accept &&
                         (32'(to_cnt) >= TIMEOUT_CYC - 1);
    assign next_idx   = idx + IDX_ONE;
    assign more_words = 32'(next_idx) < 32'(len);
    assign len_new    = {rx_data, len[7:0]};
    assign wr_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'({idx, 2'b00});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            len              <= '0;
            word             <= '0;
            byte_cnt         <= '0;
            idx              <= '0;
            csum             <= '0;
            to_cnt           <= '0;
            rx_ready         <= 1'b0;
            test_spm_addr    <= ADDR_W'(BASE_ADDR);
            test_spm_as_     <= 1'b1;
            test_spm_rw      <= RW_READ;
            test_spm_wr_data <= '0;
            cpu_en           <= 1'b0;
            load_done        <= 1'b0;
            load_err         <= 1'b0;
        end else begin
            // The strobe is a one-cycle pulse; only the 4th data byte raises it.
            test_spm_as_ <= 1'b1;
            test_spm_rw  <= RW_READ;

            if (accept || !timed) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_ONE;
            end

            if (timeout_hit) begin
                state    <= S_ERR;
                load_err <= 1'b1;
                rx_ready <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        rx_ready <= 1'b1;
                        if (accept && rx_data == START) begin
                            state    <= S_LEN_LO;
                            csum     <= '0;
                            idx      <= '0;
                            byte_cnt <= '0;
                        end
                    end
                    S_LEN_LO: begin
                        if (accept) begin
                            len[7:0] <= rx_data;
                            state    <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (accept) begin
                            len[15:8] <= rx_data;
                            if (32'(len_new) > MAX_WORDS) begin
                                state    <= S_ERR;
                                load_err <= 1'b1;
                            end else if (len_new == 16'd0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            csum     <= csum + rx_data;
                            byte_cnt <= byte_cnt + 2'd1;
                            case (byte_cnt)
                                2'd0: word[7:0]   <= rx_data;
                                2'd1: word[15:8]  <= rx_data;
                                2'd2: word[23:16] <= rx_data;
                                default: begin
                                    state            <= S_WRITE;
                                    rx_ready         <= 1'b0;
                                    test_spm_as_     <= 1'b0;
                                    test_spm_rw      <= RW_WRITE;
                                    test_spm_addr    <= wr_addr;
                                    test_spm_wr_data <= {rx_data, word};
                                end
                            endcase
                        end
                    end
                    S_WRITE: begin
                        idx      <= next_idx;
                        rx_ready <= 1'b1;
                        state    <= more_words ? S_DATA : S_CSUM;
                    end
                    S_CSUM: begin
                        if (accept) begin
                            if (rx_data == csum) begin
                                state     <= S_DONE;
                                cpu_en    <= 1'b1;
                                load_done <= 1'b1;
                                rx_ready  <= 1'b0;
                            end else begin
                                state    <= S_ERR;
                                load_err <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        rx_ready <= 1'b0;
                        cpu_en   <= 1'b1;
                    end
                    S_ERR: begin
                        rx_ready <= 1'b1;
                        cpu_en   <= 1'b0;
                        if (accept && rx_data == START) begin
                            load_err <= 1'b0;
                            state    <= S_LEN_LO;
                            csum     <= '0;
                            idx      <= '0;
                            byte_cnt <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spm_boot_loader.sv
// Directed bench for spm_boot_loader. Stimulus pushes expected SPM writes
// into a queue; a negedge monitor pops and compares on every strobe.
module tb_spm_boot_loader;

    localparam int unsigned BASE = 32'h40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [29:0] test_spm_addr;
    logic        test_spm_as_;
    logic        test_spm_rw;
    logic [31:0] test_spm_wr_data;
    logic        cpu_en;
    logic        load_done;
    logic        load_err;

    spm_boot_loader #(
        .BASE_ADDR   (BASE),
        .MAX_WORDS   (64),
        .TIMEOUT_CYC (100),
        .ADDR_W      (30)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .test_spm_addr    (test_spm_addr),
        .test_spm_as_     (test_spm_as_),
        .test_spm_rw      (test_spm_rw),
        .test_spm_wr_data (test_spm_wr_data),
        .cpu_en           (cpu_en),
        .load_done        (load_done),
        .load_err         (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] bq[$];
    int tests = 0;
    int fails = 0;
    int strobes = 0;
    int exp_strobes = 0;
    int stalls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input int idx, input logic [31:0] data);
        wr_t e;
        e.addr = 30'(BASE + 4 * idx);
        e.data = data;
        exp_q.push_back(e);
        exp_strobes++;
    endtask

    // Sends every byte in bq; gap = idle cycles with rx_valid low between bytes.
    task automatic send_list(input int gap);
        logic s;
        int   n;
        for (int i = 0; i < bq.size(); i++) begin
            rx_data  = bq[i];
            rx_valid = 1'b1;
            n = 0;
            do begin
                s = rx_ready;
                @(negedge clk);
                if (!s) stalls++;
                n++;
            end while (!s && n < 200);
            if (!s) begin
                tests++;
                fails++;
                $display("FAIL byte_accept_timeout: got rx_ready 0 for 200 cycles, expected 1");
            end
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_good();
        push_word(0, 32'h0000_0013);
        push_word(1, 32'h0010_0093);
    endtask

    // Scoreboard monitor: every strobe must match the next expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!reset) begin
            if (test_spm_as_ == 1'b0) begin
                strobes++;
                check("strobe_rw", 32'(test_spm_rw), 32'h0);
                check("strobe_rx_ready", 32'(rx_ready), 32'h0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got addr %h data %h, expected no strobe",
                             test_spm_addr, test_spm_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("spm_addr", 32'(test_spm_addr), 32'(e.addr));
                    check("spm_wr_data", test_spm_wr_data, e.data);
                end
            end else begin
                check("idle_rw", 32'(test_spm_rw), 32'h1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check("rst_as_", 32'(test_spm_as_), 32'h1);
        check("rst_rw", 32'(test_spm_rw), 32'h1);
        check("rst_addr", 32'(test_spm_addr), BASE);
        check("rst_wr_data", test_spm_wr_data, 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h0);
        check("rst_cpu_en", 32'(cpu_en), 32'h0);
        check("rst_load_done", 32'(load_done), 32'h0);
        check("rst_load_err", 32'(load_err), 32'h0);
        do_reset();
        check("idle_rx_ready", 32'(rx_ready), 32'h1);

        // Scenario 1: good two-word frame with gaps between bytes.
        push_good();
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_list(1);
        check("s1_cpu_en_before_csum", 32'(cpu_en), 32'h0);
        bq = '{8'hB6};
        send_list(0);
        check("s1_cpu_en", 32'(cpu_en), 32'h1);
        check("s1_load_done", 32'(load_done), 32'h1);
        check("s1_load_err", 32'(load_err), 32'h0);
        check("s1_rx_ready_done", 32'(rx_ready), 32'h0);
        repeat (5) @(negedge clk);
        check("s1_cpu_en_held", 32'(cpu_en), 32'h1);

        // Scenario 2: bad checksum, then recovery.
        do_reset();
        push_good();
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
        send_list(0);
        check("s2_load_err", 32'(load_err), 32'h1);
        check("s2_cpu_en", 32'(cpu_en), 32'h0);
        check("s2_load_done", 32'(load_done), 32'h0);
        check("s2_err_rx_ready", 32'(rx_ready), 32'h1);
        bq = '{8'h00, 8'h5A};
        send_list(0);
        check("s2_err_sticky", 32'(load_err), 32'h1);
        push_good();
        bq = '{8'hA5};
        send_list(0);
        check("s2_err_cleared", 32'(load_err), 32'h0);
        bq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send_list(0);
        check("s2_cpu_en", 32'(cpu_en), 32'h1);

        // Scenario 3: junk bytes before the frame are discarded.
        do_reset();
        push_good();
        bq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send_list(2);
        check("s3_cpu_en", 32'(cpu_en), 32'h1);
        check("s3_load_done", 32'(load_done), 32'h1);

        // Scenario 4: N = 65 exceeds MAX_WORDS.
        do_reset();
        bq = '{8'hA5, 8'h41, 8'h00};
        send_list(0);
        check("s4_load_err", 32'(load_err), 32'h1);
        repeat (5) @(negedge clk);
        check("s4_cpu_en", 32'(cpu_en), 32'h0);

        // N = 0: only the zero checksum follows.
        do_reset();
        bq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_list(0);
        check("n0_load_done", 32'(load_done), 32'h1);
        check("n0_cpu_en", 32'(cpu_en), 32'h1);

        // Scenario 5: mid-frame stall aborts after 100 idle cycles.
        do_reset();
        bq = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00};
        send_list(0);
        repeat (90) @(negedge clk);
        check("s5_no_err_early", 32'(load_err), 32'h0);
        repeat (20) @(negedge clk);
        check("s5_timeout_err", 32'(load_err), 32'h1);
        check("s5_cpu_en", 32'(cpu_en), 32'h0);

        // Reset asserted during the WRITE cycle.
        do_reset();
        push_word(0, 32'h4433_2211);
        bq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_list(0);
        check("rw_strobe_active", 32'(test_spm_as_), 32'h0);
        #1 reset = 1'b1;
        #1;
        check("rw_as_after_reset", 32'(test_spm_as_), 32'h1);
        check("rw_cpu_en_after_reset", 32'(cpu_en), 32'h0);
        check("rw_rx_ready_after_reset", 32'(rx_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Scenario 6: rx_valid held high; stalls only in the two WRITE cycles.
        stalls = 0;
        push_good();
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send_list(0);
        check("s6_stall_cycles", 32'(stalls), 32'd2);
        check("s6_cpu_en", 32'(cpu_en), 32'h1);

        repeat (3) @(negedge clk);
        check("total_strobes", 32'(strobes), 32'(exp_strobes));
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
